ether_sfd_strip: RTL and testbench



---
 rtl/ether_sfd_strip.sv | 158 +++++++++++++++
 tb/tb_ether_sfd_strip.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ether_sfd_strip.sv
// ---------------------------------------------------------------------------
// ether_sfd_strip
//
// Receive-side framing stage between the PHY nibble interface and the CRC
// checker. It locks onto the preamble and start-of-frame delimiter, then
// forwards only the post-SFD nibbles (destination MAC through FCS) as a
// valid-qualified nibble stream. It also marks frame start and frame end, and
// it reports length and framing errors at frame end.
//
// Ports
//   clk        in   system clock, one nibble per cycle while crsdv=1
//   rst        in   asynchronous active-high reset
//   rxd[3:0]   in   PHY receive nibble
//   crsdv      in   PHY carrier / data valid
//   axiod[3:0] out  forwarded payload nibble (1-cycle latency from rxd)
//   axiov      out  axiod valid; high only for nibbles that arrive in DATA
//   sof        out  pulse coincident with the first forwarded nibble
//   eof        out  pulse in the cycle after the last forwarded nibble
//   frame_err  out  framing error, meaningful only while eof=1
//   frame_len  out  nibble count of the last frame, held until the next eof
// ---------------------------------------------------------------------------
module ether_sfd_strip #(
  parameter int PREAMBLE_MIN = 8,
  parameter int MIN_NIBBLES  = 128,
  parameter int MAX_NIBBLES  = 3036,
  parameter int LEN_W        = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       rxd,
  input  logic             crsdv,
  output logic [3:0]       axiod,
  output logic             axiov,
  output logic             sof,
  output logic             eof,
  output logic             frame_err,
  output logic [LEN_W-1:0] frame_len
);

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    WAIT_IDLE
  } state_t;

  localparam logic [3:0]       NIB_PRE  = 4'h5;
  localparam logic [3:0]       NIB_SFD  = 4'hD;
  localparam logic [3:0]       PCNT_MIN = 4'(PREAMBLE_MIN);
  localparam logic [3:0]       PCNT_SAT = 4'hF;
  localparam logic [LEN_W-1:0] LEN_MIN  = LEN_W'(MIN_NIBBLES);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_NIBBLES);
  localparam logic [LEN_W-1:0] LEN_SAT  = '1;

  state_t           r_state;
  logic [3:0]       r_pcnt;
  logic [LEN_W-1:0] r_len;
  logic [3:0]       r_axiod;
  logic             r_axiov;
  logic             r_sof;
  logic             r_eof;
  logic             r_frame_err;
  logic [LEN_W-1:0] r_frame_len;

  logic [3:0]       w_pcnt_inc;
  logic [LEN_W-1:0] w_len_inc;
  logic             w_len_bad;

  // Both counters saturate so a very long preamble or an oversized frame can
  // never wrap back into a legal-looking value.
  assign w_pcnt_inc = (r_pcnt == PCNT_SAT) ? r_pcnt : r_pcnt + 4'd1;
  assign w_len_inc  = (r_len == LEN_SAT) ? r_len : r_len + LEN_W'(1);

  // An odd nibble count means a trailing half byte.
  assign w_len_bad  = r_len[0] | (r_len < LEN_MIN) | (r_len > LEN_MAX);

  // NOTE: every register, including FSM state and counters, is cleared by the
  // asynchronous reset and assigned with <= only, so all readers in this block
  // see the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pcnt      <= '0;
      r_len       <= '0;
      r_axiod     <= '0;
      r_axiov     <= 1'b0;
      r_sof       <= 1'b0;
      r_eof       <= 1'b0;
      r_frame_err <= 1'b0;
      r_frame_len <= '0;
    end else begin
      // Pulses and valid default low; only DATA raises them.
      r_axiov <= 1'b0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;

      case (r_state)
        IDLE: begin
          if (crsdv) begin
            if (rxd == NIB_PRE) begin
              r_state <= PREAMBLE;
              r_pcnt  <= 4'd1;
            end else begin
              r_state <= WAIT_IDLE;
            end
          end
        end

        PREAMBLE: begin
          if (!crsdv) begin
            r_state <= IDLE;
          end else if (rxd == NIB_PRE) begin
            r_pcnt <= w_pcnt_inc;
          end else if ((rxd == NIB_SFD) && (r_pcnt >= PCNT_MIN)) begin
            // The SFD itself is consumed here and never forwarded.
            r_state <= DATA;
            r_len   <= '0;
          end else begin
            r_state <= WAIT_IDLE;
          end
        end

        DATA: begin
          if (crsdv) begin
            r_axiod <= rxd;
            r_axiov <= 1'b1;
            // r_len is still zero only for the first payload nibble; once
            // saturated it never returns to zero, so sof cannot repeat.
            r_sof   <= (r_len == '0);
            r_len   <= w_len_inc;
          end else begin
            r_eof       <= 1'b1;
            r_frame_len <= r_len;
            r_frame_err <= w_len_bad;
            r_state     <= IDLE;
          end
        end

        WAIT_IDLE: begin
          // Drop the rest of an unusable burst; wait for carrier to drop.
          if (!crsdv) begin
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign axiod     = r_axiod;
  assign axiov     = r_axiov;
  assign sof       = r_sof;
  assign eof       = r_eof;
  assign frame_err = r_frame_err;
  assign frame_len = r_frame_len;

endmodule

// File: tb/tb_ether_sfd_strip.sv
module tb_ether_sfd_strip;

  localparam int LEN_W = 12;

  logic             clk;
  logic             rst;
  logic [3:0]       rxd;
  logic             crsdv;
  logic [3:0]       axiod;
  logic             axiov;
  logic             sof;
  logic             eof;
  logic             frame_err;
  logic [LEN_W-1:0] frame_len;

  ether_sfd_strip #(
    .PREAMBLE_MIN(8),
    .MIN_NIBBLES (128),
    .MAX_NIBBLES (3036),
    .LEN_W       (LEN_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .crsdv    (crsdv),
    .axiod    (axiod),
    .axiov    (axiov),
    .sof      (sof),
    .eof      (eof),
    .frame_err(frame_err),
    .frame_len(frame_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard entries: what must appear, and at which cycle.
  typedef struct {
    logic [3:0] d;
    logic       first;
    int         due;
  } nib_t;

  typedef struct {
    logic [LEN_W-1:0] len;
    logic             err;
    int               due;
  } eof_t;

  nib_t dq[$];
  eof_t eq[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: runs on the falling edge, half a cycle away from the DUT update.
  always @(negedge clk) begin
    if (!rst) begin
      if (axiov) begin
        if (dq.size() == 0) begin
          check("unexpected_axiov", 32'd1, 32'd0);
        end else begin
          nib_t e;
          e = dq.pop_front();
          check("axiod", {28'd0, axiod}, {28'd0, e.d});
          check("sof", {31'd0, sof}, {31'd0, e.first});
          check("nib_latency", cyc, e.due);
        end
      end else if (sof) begin
        check("sof_without_axiov", {31'd0, sof}, 32'd0);
      end
      if (eof) begin
        if (eq.size() == 0) begin
          check("unexpected_eof", 32'd1, 32'd0);
        end else begin
          eof_t f;
          f = eq.pop_front();
          check("frame_len", {20'd0, frame_len}, {20'd0, f.len});
          check("frame_err", {31'd0, frame_err}, {31'd0, f.err});
          check("eof_latency", cyc, f.due);
          check("eof_axiov_low", {31'd0, axiov}, 32'd0);
        end
      end
    end
  end

  // ---- stimulus helpers -------------------------------------------------
  task automatic step(input logic dv, input logic [3:0] d);
    @(negedge clk);
    crsdv = dv;
    rxd   = d;
  endtask

  task automatic data_nib(input logic [3:0] d, input logic first);
    nib_t e;
    step(1'b1, d);
    e.d = d; e.first = first; e.due = cyc + 1;
    dq.push_back(e);
  endtask

  task automatic end_frame(input int len, input logic err);
    eof_t f;
    step(1'b0, 4'h0);
    f.len = LEN_W'(len); f.err = err; f.due = cyc + 1;
    eq.push_back(f);
  endtask

  task automatic preamble(input int n);
    repeat (n) step(1'b1, 4'h5);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 4'h0);
  endtask

  task automatic random_frame(input int pre, input int n, input logic err);
    preamble(pre);
    step(1'b1, 4'hD);
    for (int i = 0; i < n; i++) data_nib(4'($urandom_range(0, 15)), i == 0);
    end_frame(n, err);
  endtask

  task automatic clean_frame();
    logic [3:0] crc[8];
    crc = '{4'hA, 4'h6, 4'hC, 4'h0, 4'hD, 4'hA, 4'hC, 4'h3};
    preamble(15);
    step(1'b1, 4'hD);
    for (int i = 0; i < 128; i++) data_nib(4'h5, i == 0);
    for (int i = 0; i < 8; i++) data_nib(crc[i], 1'b0);
    end_frame(136, 1'b0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_axiod"}, {28'd0, axiod}, 32'd0);
    check({tag, "_axiov"}, {31'd0, axiov}, 32'd0);
    check({tag, "_sof"}, {31'd0, sof}, 32'd0);
    check({tag, "_eof"}, {31'd0, eof}, 32'd0);
    check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    check({tag, "_frame_len"}, {20'd0, frame_len}, 32'd0);
  endtask

  // ---- directed sequence ------------------------------------------------
  initial begin
    rst   = 1'b1;
    crsdv = 1'b0;
    rxd   = 4'h0;
    idle(3);
    check_outputs_zero("reset");
    rst = 1'b0;
    idle(2);

    // Clean frame with the reference CRC tail.
    clean_frame();
    idle(3);

    // Short preamble: dropped, then a clean frame right after carrier drops.
    preamble(4);
    step(1'b1, 4'hD);
    for (int i = 0; i < 20; i++) step(1'b1, 4'(i));
    step(1'b0, 4'h0);
    clean_frame();

    // Back-to-back: a new preamble on the very next cycle after eof.
    clean_frame();
    idle(2);

    // Bad nibble inside the preamble drops the whole burst.
    preamble(10);
    step(1'b1, 4'h7);
    step(1'b1, 4'hD);
    for (int i = 0; i < 16; i++) step(1'b1, 4'hB);
    step(1'b0, 4'h0);
    clean_frame();
    idle(2);

    // Preamble of 7 is one short; exactly 8 is accepted.
    preamble(7);
    step(1'b1, 4'hD);
    for (int i = 0; i < 10; i++) step(1'b1, 4'h1);
    step(1'b0, 4'h0);
    random_frame(8, 37, 1'b1);    // odd and short
    idle(2);
    random_frame(9, 126, 1'b1);   // even but below minimum
    idle(2);
    random_frame(12, 128, 1'b0);  // exactly minimum
    idle(2);
    random_frame(12, 3036, 1'b0); // exactly maximum
    idle(2);
    random_frame(12, 3040, 1'b1); // oversize still forwarded
    idle(2);

    // Single-cycle carrier glitch ends the frame; the rest of the burst
    // starts with a non-preamble nibble and is discarded.
    preamble(8);
    step(1'b1, 4'hD);
    for (int i = 0; i < 130; i++) data_nib(4'($urandom_range(0, 15)), i == 0);
    end_frame(130, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 4'hA);
    idle(2);

    // Asynchronous reset in the middle of DATA.
    preamble(8);
    step(1'b1, 4'hD);
    for (int i = 0; i < 49; i++) data_nib(4'($urandom_range(0, 15)), i == 0);
    @(negedge clk);
    crsdv = 1'b1;
    rxd   = 4'h5;
    #1 rst = 1'b1;
    #1 check_outputs_zero("async_rst");
    check("async_rst_pending", dq.size(), 32'd0);
    step(1'b0, 4'h0);
    step(1'b0, 4'h0);
    rst = 1'b0;
    idle(2);
    clean_frame();
    idle(4);

    check("leftover_nibbles", dq.size(), 32'd0);
    check("leftover_eofs", eq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
